// File: rtl/serial_bus_master_p_if.sv
// Command handshake and serial bus signals of serial_bus_master_p.
// The master modport is the bus master; the slave modport is the user/arbiter/slave side.
interface serial_bus_master_p_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              bus_req;
  logic              bus_grant;
  logic              valid_s;
  logic              write_en_slave;
  logic              addr_tx;
  logic              data_tx;
  logic              data_rx;
  logic              slave_valid;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, bus_grant, data_rx, slave_valid,
    output cmd_ready, bus_req, valid_s, write_en_slave, addr_tx, data_tx, done, err,
           rd_data, busy
  );

  modport slave (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, bus_grant, data_rx, slave_valid,
    input  cmd_ready, bus_req, valid_s, write_en_slave, addr_tx, data_tx, done, err,
           rd_data, busy
  );
endinterface

// File: rtl/serial_bus_master_p.sv
// Parametrised 1-bit serial bus master: one command at a time, MSB-first address/data,
// bounded retry on grant loss, read timeout and a done pulse qualified by err.
module serial_bus_master_p #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 3
) (
  input logic                   clock,
  input logic                   reset,
  serial_bus_master_p_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int BIT_W = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [BIT_W-1:0] ADDR_LAST  = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] WDATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] RDATA_LAST = BIT_W'(DATA_W - 2);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);

  logic [2:0]        state;
  logic              read_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_sr;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] rd_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [RTY_W-1:0]  rty_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      read_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      addr_sr  <= '0;
      wdata_q  <= '0;
      wdata_sr <= '0;
      rx_sr    <= '0;
      rd_q     <= '0;
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      rty_cnt  <= '0;
    end else if ((state == S_ADDR || state == S_WDATA) && !bus.bus_grant) begin
      // Grant lost mid-frame: retry the whole frame or give up once the budget is spent.
      bit_cnt <= '0;
      if (rty_cnt == RTY_MAX) begin
        state <= S_DONE;
        err_q <= 1'b1;
        if (read_q) rd_q <= '0;
      end else begin
        state   <= S_REQ;
        rty_cnt <= rty_cnt + RTY_W'(1);
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            read_q  <= bus.cmd_read;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            err_q   <= 1'b0;
            rty_cnt <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.bus_grant) begin
            addr_sr  <= addr_q;
            wdata_sr <= wdata_q;
            bit_cnt  <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          addr_sr <= addr_sr << 1;
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            state   <= read_q ? S_RWAIT : S_WDATA;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_WDATA: begin
          wdata_sr <= wdata_sr << 1;
          if (bit_cnt == WDATA_LAST) state <= S_DONE;
          else                       bit_cnt <= bit_cnt + BIT_W'(1);
        end
        S_RWAIT: begin
          // The first read bit arrives together with slave_valid.
          if (bus.slave_valid) begin
            rx_sr   <= (DATA_W-1)'({rx_sr, bus.data_rx});
            bit_cnt <= '0;
            state   <= S_RDATA;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            rd_q  <= '0;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_RDATA: begin
          rx_sr <= (DATA_W-1)'({rx_sr, bus.data_rx});
          if (bit_cnt == RDATA_LAST) begin
            rd_q  <= {rx_sr, bus.data_rx};
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = (state == S_IDLE);
  assign bus.busy           = (state != S_IDLE);
  assign bus.bus_req        = (state != S_IDLE) && (state != S_DONE);
  assign bus.valid_s        = (state == S_ADDR) || (state == S_WDATA) ||
                              (state == S_RWAIT) || (state == S_RDATA);
  assign bus.write_en_slave = (state != S_IDLE) && !read_q;
  assign bus.addr_tx        = (state == S_ADDR) && addr_sr[ADDR_W-1];
  assign bus.data_tx        = (state == S_WDATA) && wdata_sr[DATA_W-1];
  assign bus.done           = (state == S_DONE);
  assign bus.err            = (state == S_DONE) && err_q;
  assign bus.rd_data        = rd_q;
endmodule

// File: tb/tb_serial_bus_master_p.sv
// Randomised bench for serial_bus_master_p: the driver plays user, arbiter and slave,
// a reference model predicts each completion and a separate monitor scores done pulses.
module tb_serial_bus_master_p;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int MR  = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  serial_bus_master_p_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  serial_bus_master_p #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_RETRY(MR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int          gdly;      // REQ cycles before each grant
    int          drops;     // frames that lose the grant
    int          drop_k;    // frame bit at which the grant drops, -1 = random
    int          sv_delay;  // RWAIT cycles before slave_valid, >= TMO means never
    int          rst_at;    // write-data bit at which reset hits, -1 = none
  } txn_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] rd;
  } resp_t;

  resp_t         exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] model_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Outcome follows from the command and the environment plan alone.
  function automatic resp_t model(input txn_t t, input logic [DW-1:0] last_rd);
    resp_t r;
    r.err = (t.drops > MR) || (t.read && t.sv_delay >= TMO);
    if (!t.read)    r.rd = last_rd;
    else if (r.err) r.rd = '0;
    else            r.rd = t.rdata;
    return r;
  endfunction

  function automatic txn_t mk(input bit rd, input int addr, input int wdata, input int rdata,
                              input int gdly, input int drops, input int drop_k,
                              input int sv_delay, input int rst_at);
    txn_t t;
    t.read = rd;       t.addr = AW'(addr);  t.wdata = DW'(wdata); t.rdata = DW'(rdata);
    t.gdly = gdly;     t.drops = drops;     t.drop_k = drop_k;
    t.sv_delay = sv_delay; t.rst_at = rst_at;
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_bus_req"}, bus.bus_req, 0);
    check({tag, "_valid_s"}, bus.valid_s, 0);
    check({tag, "_write_en"}, bus.write_en_slave, 0);
    check({tag, "_addr_tx"}, bus.addr_tx, 0);
    check({tag, "_data_tx"}, bus.data_tx, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
  endtask

  task automatic run_txn(input txn_t t);
    int    w;
    int    flen;
    int    k_drop;
    bit    dropped;
    resp_t r;

    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    if (bus.cmd_ready !== 1'b1) return;

    bus.cmd_valid = 1'b1;
    bus.cmd_read  = t.read;
    bus.cmd_addr  = t.addr;
    bus.cmd_wdata = t.wdata;
    if (t.rst_at < 0) begin
      r = model(t, model_rd);
      model_rd = r.rd;
      exp_q.push_back(r);
    end
    tick();
    // Scramble the command bus: the master must work from its shadow copy.
    bus.cmd_valid = 1'b0;
    bus.cmd_read  = 1'($urandom_range(1, 0));
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    check("bus_req_after_accept", bus.bus_req, 1);
    check("write_en_slave", bus.write_en_slave, !t.read);

    flen = AW + (t.read ? 0 : DW);
    for (int f = 0; ; f++) begin
      dropped = (f < t.drops);
      k_drop  = (t.drop_k >= 0) ? t.drop_k : $urandom_range(flen - 1, 0);
      for (int i = 0; i < t.gdly; i++) begin
        bus.cmd_valid = 1'($urandom_range(1, 0));
        tick();
        bus.cmd_valid = 1'b0;
        check("req_wait_valid_s", bus.valid_s, 0);
      end
      bus.bus_grant = 1'b1;
      tick();
      for (int k = 0; k < flen; k++) begin
        check("frame_valid_s", bus.valid_s, 1);
        if (k < AW) begin
          check("addr_tx", bus.addr_tx, t.addr[AW-1-k]);
          check("data_tx_in_addr", bus.data_tx, 0);
        end else begin
          check("data_tx", bus.data_tx, t.wdata[DW-1-(k-AW)]);
          check("addr_tx_in_data", bus.addr_tx, 0);
        end
        if (t.rst_at >= 0 && k == AW + t.rst_at) begin
          reset = 1'b1;
          #1;
          check_reset_outputs("mid_reset");
          tick();
          reset = 1'b0;
          bus.bus_grant = 1'b0;
          model_rd = '0;
          check("mid_reset_no_done", bus.done, 0);
          return;
        end
        if (dropped && k == k_drop) begin
          bus.bus_grant = 1'b0;
          tick();
          if (f == MR) begin
            check("abort_done", bus.done, 1);
            tick();
            check("ready_after_abort", bus.cmd_ready, 1);
            return;
          end
          check("loss_valid_s", bus.valid_s, 0);
          check("loss_bus_req", bus.bus_req, 1);
          break;
        end
        tick();
      end
      if (!dropped) break;
    end

    if (t.read) begin
      for (int i = 0; i < TMO && i < t.sv_delay; i++) begin
        check("rwait_valid_s", bus.valid_s, 1);
        bus.bus_grant = 1'($urandom_range(1, 0));
        tick();
      end
      if (t.sv_delay < TMO) begin
        for (int j = 0; j < DW; j++) begin
          check("rdata_valid_s", bus.valid_s, 1);
          bus.slave_valid = (j == 0);
          bus.data_rx     = t.rdata[DW-1-j];
          bus.bus_grant   = 1'($urandom_range(1, 0));
          tick();
        end
        bus.slave_valid = 1'b0;
        bus.data_rx     = 1'b0;
      end
    end
    bus.bus_grant = 1'b0;
    check("done_latency", bus.done, 1);
    tick();
    check("ready_after_done", bus.cmd_ready, 1);
    check("busy_after_done", bus.busy, 0);
  endtask

  // Scoreboard monitor: independent of the driver, pops one prediction per done pulse.
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        if (bus.done === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", bus.done, 0);
          end else begin
            r = exp_q.pop_front();
            check("err", bus.err, r.err);
            check("rd_data", bus.rd_data, r.rd);
            check("done_bus_req", bus.bus_req, 0);
            check("done_valid_s", bus.valid_s, 0);
          end
        end else if (bus.err === 1'b1) begin
          check("err_without_done", bus.err, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    int   v;
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_read    = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.bus_grant   = 1'b0;
    bus.data_rx     = 1'b0;
    bus.slave_valid = 1'b0;
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    run_txn(mk(1'b0, 'h2A5C, 'hA5, 0,    0, 0,      -1, 0,       -1));
    run_txn(mk(1'b1, 'h0013, 0,    'h3C, 2, 0,      -1, 5,       -1));
    run_txn(mk(1'b0, 'h1234, 'h5A, 0,    1, 1,       4, 0,       -1));
    run_txn(mk(1'b0, 'h3FFF, 'hFF, 0,    0, MR + 1, -1, 0,       -1));
    run_txn(mk(1'b1, 'h2001, 0,    'h81, 1, 0,      -1, TMO,     -1));
    run_txn(mk(1'b1, 'h0F0F, 0,    'hC3, 0, 0,      -1, TMO - 1, -1));
    run_txn(mk(1'b1, 'h1111, 0,    'h77, 0, 2,      -1, 0,       -1));
    run_txn(mk(1'b0, 'h0ACE, 'h96, 0,    0, 0,      -1, 0,        3));
    run_txn(mk(1'b0, 'h2A5C, 'hA5, 0,    0, 0,      -1, 0,       -1));

    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(9, 0);
      t = mk(1'($urandom_range(1, 0)), int'($urandom), int'($urandom), int'($urandom),
             $urandom_range(3, 0), 0, -1, $urandom_range(TMO + 2, 0), -1);
      if (v >= 9)      t.drops = MR + 1;
      else if (v >= 6) t.drops = $urandom_range(MR, 1);
      run_txn(t);
    end

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
